// File: rtl/trigger_out_shaper.sv
// Trigger output shaper: turns the trigger generator's detect levels into a width-programmable
// pulse with hold-off, latches the TOF word for readout and counts events. Optional macro: TRIG_OUT_SYNC_EN.
module trigger_out_shaper #(
    parameter int CNT_WIDTH = 16,
    parameter int PW_WIDTH  = 16
) (
    input  logic                 rxclk,
    input  logic                 rst,
    input  logic                 trig_enable,
    input  logic                 detect_pls_0,
    input  logic                 detect_pls_1,
    input  logic [31:0]          pulse_tof,
    input  logic [PW_WIDTH-1:0]  pulse_width,
    input  logic [31:0]          holdoff,
    input  logic                 cnt_clr,
    input  logic                 tof_ack,
    output logic                 trig_out,
    output logic                 pls0_out,
    output logic [31:0]          tof_latched,
    output logic                 tof_valid,
    output logic                 tof_overrun,
    output logic                 armed,
    output logic [CNT_WIDTH-1:0] event_count,
    output logic [CNT_WIDTH-1:0] missed_count
);

    localparam int TW = (PW_WIDTH > 32) ? PW_WIDTH : 32;

    typedef enum logic [1:0] {IDLE = 2'd0, PULSE = 2'd1, HOLDOFF = 2'd2} state_t;

    state_t                 state_r, state_nx;
    logic [TW-1:0]          cnt_r, cnt_nx;
    logic                   trig_r, trig_nx;
    logic                   d1_r, pls0_r, valid_r, ovr_r;
    logic [31:0]            tof_r;
    logic [CNT_WIDTH-1:0]   evt_r, miss_r;
    logic                   det0_s, det1_s, rise_s, capture_s, missed_s;
    logic [31:0]            tof_s;

    // Counters hold remaining cycles minus one, so a zero width still yields one high cycle.
    function automatic logic [TW-1:0] width_load(input logic [PW_WIDTH-1:0] pw);
        if (pw == {PW_WIDTH{1'b0}}) return {TW{1'b0}};
        else                        return TW'(pw) - TW'(1'b1);
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        if (&c) return c;
        else    return c + CNT_WIDTH'(1'b1);
    endfunction

`ifdef TRIG_OUT_SYNC_EN
    logic [1:0]  p0_sync_r, p1_sync_r;
    logic [31:0] tof_d1_r, tof_d2_r;

    // Two-flop synchronizers; TOF word delayed alongside so it stays aligned with its trigger.
    always_ff @(posedge rxclk or posedge rst) begin
        if (rst) begin
            p0_sync_r <= 2'b00;
            p1_sync_r <= 2'b00;
            tof_d1_r  <= 32'd0;
            tof_d2_r  <= 32'd0;
        end else begin
            p0_sync_r <= {p0_sync_r[0], detect_pls_0};
            p1_sync_r <= {p1_sync_r[0], detect_pls_1};
            tof_d1_r  <= pulse_tof;
            tof_d2_r  <= tof_d1_r;
        end
    end

    assign det0_s = p0_sync_r[1];
    assign det1_s = p1_sync_r[1];
    assign tof_s  = tof_d2_r;
`else
    assign det0_s = detect_pls_0;
    assign det1_s = detect_pls_1;
    assign tof_s  = pulse_tof;
`endif

    assign rise_s = det1_s & ~d1_r & trig_enable;
    assign armed  = (state_r == IDLE) & trig_enable & ~rst;

    // Next-state and pulse/holdoff counter logic.
    always_comb begin
        state_nx  = state_r;
        cnt_nx    = cnt_r;
        trig_nx   = 1'b0;
        capture_s = 1'b0;
        missed_s  = 1'b0;
        if (!trig_enable) begin
            state_nx = IDLE;
            cnt_nx   = {TW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (rise_s) begin
                        state_nx  = PULSE;
                        cnt_nx    = width_load(pulse_width);
                        trig_nx   = 1'b1;
                        capture_s = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
                PULSE: begin
                    missed_s = rise_s;
                    if (cnt_r != {TW{1'b0}}) begin
                        cnt_nx  = cnt_r - TW'(1'b1);
                        trig_nx = 1'b1;
                    end else if (holdoff == 32'd0) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = HOLDOFF;
                        cnt_nx   = TW'(holdoff) - TW'(1'b1);
                    end
                end
                HOLDOFF: begin
                    missed_s = rise_s;
                    if (cnt_r != {TW{1'b0}}) begin
                        cnt_nx = cnt_r - TW'(1'b1);
                    end else begin
                        state_nx = IDLE;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = {TW{1'b0}};
                end
            endcase
        end
    end

    // State, counter, edge register and registered pulse outputs.
    always_ff @(posedge rxclk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {TW{1'b0}};
            trig_r  <= 1'b0;
            d1_r    <= 1'b0;
            pls0_r  <= 1'b0;
        end else begin
            state_r <= state_nx;
            cnt_r   <= cnt_nx;
            trig_r  <= trig_nx;
            d1_r    <= det1_s;
            pls0_r  <= det0_s & trig_enable;
        end
    end

    // TOF latch with valid/ack handshake; a capture beats a same-cycle ack.
    always_ff @(posedge rxclk or posedge rst) begin
        if (rst) begin
            tof_r   <= 32'd0;
            valid_r <= 1'b0;
            ovr_r   <= 1'b0;
        end else begin
            if (capture_s) tof_r <= tof_s;
            else           tof_r <= tof_r;
            if (capture_s)    valid_r <= 1'b1;
            else if (tof_ack) valid_r <= 1'b0;
            else              valid_r <= valid_r;
            if (cnt_clr)                             ovr_r <= 1'b0;
            else if (capture_s & valid_r & ~tof_ack) ovr_r <= 1'b1;
            else                                     ovr_r <= ovr_r;
        end
    end

    // Saturating event and missed-event counters; clear wins over increment.
    always_ff @(posedge rxclk or posedge rst) begin
        if (rst) begin
            evt_r  <= {CNT_WIDTH{1'b0}};
            miss_r <= {CNT_WIDTH{1'b0}};
        end else if (cnt_clr) begin
            evt_r  <= {CNT_WIDTH{1'b0}};
            miss_r <= {CNT_WIDTH{1'b0}};
        end else begin
            evt_r  <= capture_s ? sat_inc(evt_r) : evt_r;
            miss_r <= missed_s ? sat_inc(miss_r) : miss_r;
        end
    end

    assign trig_out     = trig_r;
    assign pls0_out     = pls0_r;
    assign tof_latched  = tof_r;
    assign tof_valid    = valid_r;
    assign tof_overrun  = ovr_r;
    assign event_count  = evt_r;
    assign missed_count = miss_r;

endmodule

// File: tb/tb_trigger_out_shaper.sv
// Table-driven bench for trigger_out_shaper (default build, CNT_WIDTH=4), plus hand-written
// sequences for enable abort, counter saturation and asynchronous reset mid-pulse.
module tb_trigger_out_shaper;

    logic        rxclk = 1'b0;
    logic        rst = 1'b1;
    logic        trig_enable = 1'b0, detect_pls_0 = 1'b0, detect_pls_1 = 1'b0;
    logic [31:0] pulse_tof = 32'd0, holdoff = 32'd0;
    logic [15:0] pulse_width = 16'd0;
    logic        cnt_clr = 1'b0, tof_ack = 1'b0;
    logic        trig_out, pls0_out, tof_valid, tof_overrun, armed;
    logic [31:0] tof_latched;
    logic [3:0]  event_count, missed_count;

    int n_vec = 0;
    int n_err = 0;

    trigger_out_shaper #(.CNT_WIDTH(4), .PW_WIDTH(16)) dut (
        .rxclk(rxclk), .rst(rst), .trig_enable(trig_enable),
        .detect_pls_0(detect_pls_0), .detect_pls_1(detect_pls_1),
        .pulse_tof(pulse_tof), .pulse_width(pulse_width), .holdoff(holdoff),
        .cnt_clr(cnt_clr), .tof_ack(tof_ack), .trig_out(trig_out), .pls0_out(pls0_out),
        .tof_latched(tof_latched), .tof_valid(tof_valid), .tof_overrun(tof_overrun),
        .armed(armed), .event_count(event_count), .missed_count(missed_count)
    );

    always #4 rxclk = ~rxclk;

    typedef struct {
        logic        en, d0, d1;
        logic [15:0] pw;
        logic [31:0] ho, tof;
        logic        ack, clr;
        logic        e_trig, e_pls0, e_valid, e_ovr, e_armed;
        logic [3:0]  e_evt, e_miss;
        logic [31:0] e_tof;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic en, d0, d1, input logic [15:0] pw,
                                input logic [31:0] ho, tof, input logic ack, clr,
                                input logic et, ep, ev, eo, ea,
                                input logic [3:0] ee, em, input logic [31:0] etf);
        vec_t v;
        v.en = en; v.d0 = d0; v.d1 = d1; v.pw = pw; v.ho = ho; v.tof = tof;
        v.ack = ack; v.clr = clr; v.e_trig = et; v.e_pls0 = ep; v.e_valid = ev;
        v.e_ovr = eo; v.e_armed = ea; v.e_evt = ee; v.e_miss = em; v.e_tof = etf;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge rxclk);
        #1;
    endtask

    int e_evt;

    initial begin
        // en d0 d1 pw ho  tof     ack clr | trig pls0 valid ovr armed evt miss tof
        tbl.push_back(mk(1,0,0, 4,0,'h1234, 0,0,  0,0,0,0,1, 0,0,'h0));
        tbl.push_back(mk(1,0,1, 4,0,'h1234, 0,0,  1,0,1,0,0, 1,0,'h1234));
        tbl.push_back(mk(1,1,1, 4,0,'h1234, 0,0,  1,1,1,0,0, 1,0,'h1234));
        tbl.push_back(mk(1,0,0, 4,0,'h1234, 0,0,  1,0,1,0,0, 1,0,'h1234));
        tbl.push_back(mk(1,0,0, 9,0,'h1234, 0,0,  1,0,1,0,0, 1,0,'h1234));
        tbl.push_back(mk(1,0,0, 0,0,'h10,   0,0,  0,0,1,0,1, 1,0,'h1234));
        tbl.push_back(mk(1,0,0, 0,5,'h10,   1,0,  0,0,0,0,1, 1,0,'h1234));
        tbl.push_back(mk(1,0,1, 0,5,'h10,   0,0,  1,0,1,0,0, 2,0,'h10));
        tbl.push_back(mk(1,0,0, 0,5,'h10,   0,0,  0,0,1,0,0, 2,0,'h10));
        tbl.push_back(mk(1,0,0, 0,5,'h10,   0,0,  0,0,1,0,0, 2,0,'h10));
        tbl.push_back(mk(1,0,1, 0,5,'h10,   0,0,  0,0,1,0,0, 2,1,'h10));
        tbl.push_back(mk(1,0,0, 0,5,'h10,   0,0,  0,0,1,0,0, 2,1,'h10));
        tbl.push_back(mk(1,0,0, 0,5,'h10,   0,0,  0,0,1,0,0, 2,1,'h10));
        tbl.push_back(mk(1,0,0, 0,5,'h10,   0,0,  0,0,1,0,1, 2,1,'h10));
        tbl.push_back(mk(1,0,1, 0,5,'h20,   0,0,  1,0,1,1,0, 3,1,'h20));
        tbl.push_back(mk(1,0,0, 0,0,'h20,   0,0,  0,0,1,1,1, 3,1,'h20));
        tbl.push_back(mk(1,0,0, 0,0,'h20,   1,0,  0,0,0,1,1, 3,1,'h20));
        tbl.push_back(mk(1,0,0, 0,0,'h20,   0,1,  0,0,0,0,1, 0,0,'h20));
        tbl.push_back(mk(1,0,1, 2,0,'h30,   0,0,  1,0,1,0,0, 1,0,'h30));
        tbl.push_back(mk(1,0,0, 2,0,'h30,   0,0,  1,0,1,0,0, 1,0,'h30));
        tbl.push_back(mk(1,0,0, 2,0,'h30,   0,0,  0,0,1,0,1, 1,0,'h30));
        tbl.push_back(mk(1,0,1, 2,0,'h40,   1,0,  1,0,1,0,0, 2,0,'h40));
        tbl.push_back(mk(1,0,0, 2,0,'h40,   0,0,  1,0,1,0,0, 2,0,'h40));
        tbl.push_back(mk(1,0,0, 2,0,'h40,   0,0,  0,0,1,0,1, 2,0,'h40));
        tbl.push_back(mk(1,0,1, 2,0,'h50,   1,1,  1,0,1,0,0, 0,0,'h50));
        tbl.push_back(mk(1,0,0, 2,0,'h50,   0,0,  1,0,1,0,0, 0,0,'h50));
        tbl.push_back(mk(1,0,0, 2,0,'h50,   0,0,  0,0,1,0,1, 0,0,'h50));

        // reset state
        step();
        step();
        chk("reset trig_out", trig_out, 0);
        chk("reset tof_valid", tof_valid, 0);
        chk("reset armed", armed, 0);
        chk("reset event_count", event_count, 0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            trig_enable = tbl[i].en; detect_pls_0 = tbl[i].d0; detect_pls_1 = tbl[i].d1;
            pulse_width = tbl[i].pw; holdoff = tbl[i].ho; pulse_tof = tbl[i].tof;
            tof_ack = tbl[i].ack; cnt_clr = tbl[i].clr;
            step();
            chk($sformatf("row%0d trig_out", i), trig_out, tbl[i].e_trig);
            chk($sformatf("row%0d pls0_out", i), pls0_out, tbl[i].e_pls0);
            chk($sformatf("row%0d tof_valid", i), tof_valid, tbl[i].e_valid);
            chk($sformatf("row%0d tof_overrun", i), tof_overrun, tbl[i].e_ovr);
            chk($sformatf("row%0d armed", i), armed, tbl[i].e_armed);
            chk($sformatf("row%0d event_count", i), event_count, tbl[i].e_evt);
            chk($sformatf("row%0d missed_count", i), missed_count, tbl[i].e_miss);
            chk($sformatf("row%0d tof_latched", i), tof_latched, tbl[i].e_tof);
        end
        tof_ack = 1'b0; cnt_clr = 1'b0;

        // enable abort mid-pulse, level still high at re-enable
        pulse_width = 16'd100; holdoff = 32'd0; pulse_tof = 32'h60; detect_pls_1 = 1'b1;
        step();
        chk("abort start trig_out", trig_out, 1);
        chk("abort start event_count", event_count, 1);
        for (int k = 0; k < 19; k++) step();
        chk("abort pulse cycle 20 trig_out", trig_out, 1);
        trig_enable = 1'b0; detect_pls_0 = 1'b1;
        step();
        chk("abort trig_out", trig_out, 0);
        chk("abort pls0_out gated", pls0_out, 0);
        chk("abort armed", armed, 0);
        chk("abort tof_latched kept", tof_latched, 32'h60);
        chk("abort tof_valid kept", tof_valid, 1);
        step();
        trig_enable = 1'b1;
        step();
        chk("reenable trig_out", trig_out, 0);
        chk("reenable armed", armed, 1);
        chk("reenable pls0_out", pls0_out, 1);
        step();
        chk("reenable no new trigger", trig_out, 0);
        chk("reenable event_count", event_count, 1);
        detect_pls_1 = 1'b0; detect_pls_0 = 1'b0;
        step();

        // event_count saturation at 15
        pulse_width = 16'd1;
        e_evt = 1;
        for (int k = 0; k < 20; k++) begin
            detect_pls_1 = 1'b1;
            step();
            e_evt = (e_evt < 15) ? e_evt + 1 : 15;
            chk($sformatf("sat trigger %0d event_count", k), event_count, e_evt);
            detect_pls_1 = 1'b0;
            step();
        end
        chk("sat missed_count", missed_count, 0);

        // asynchronous reset mid-pulse
        pulse_width = 16'd10; detect_pls_1 = 1'b1;
        step();
        chk("pre-reset trig_out", trig_out, 1);
        detect_pls_1 = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("async reset trig_out", trig_out, 0);
        chk("async reset event_count", event_count, 0);
        step();
        rst = 1'b0;
        step();
        chk("post-reset armed", armed, 1);
        chk("post-reset trig_out", trig_out, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/trigger_out_shaper.md
Name: trigger_out_shaper

Overview:
- Downstream stage of the time-of-flight trigger state machine, on the same 125 MHz ADC clock.
- Turns that machine's level-style detect outputs into a width-programmable trigger pulse, followed by a programmable hold-off.
- Latches the TOF word with a valid/ack handshake for register readout, and keeps event and missed-event counters.

Parameters:
- CNT_WIDTH, 16, width of event_count and missed_count (saturating).
- PW_WIDTH, 16, width of pulse_width.

Ports:
- rxclk  in  1  ADC clock, 125 MHz; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- trig_enable  in  1  synchronous enable; low forces IDLE.
- detect_pls_0  in  1  first/third-probe detect level from trigger generator.
- detect_pls_1  in  1  final trigger level from trigger generator.
- pulse_tof  in  32  TOF/wait-cycle word from trigger generator.
- pulse_width  in  PW_WIDTH  output pulse width in rxclk cycles; 0 treated as 1.
- holdoff  in  32  post-pulse dead time in cycles; 0 = no dead time.
- cnt_clr  in  1  synchronous clear of both counters.
- tof_ack  in  1  readout acknowledge; clears tof_valid.
- trig_out  out  1  shaped trigger pulse, registered.
- pls0_out  out  1  registered copy of detect_pls_0, gated by trig_enable.
- tof_latched  out  32  TOF captured at accepted trigger.
- tof_valid  out  1  tof_latched holds unread data.
- tof_overrun  out  1  sticky: accepted trigger while tof_valid high.
- armed  out  1  state == IDLE and trig_enable.
- event_count  out  CNT_WIDTH  accepted triggers.
- missed_count  out  CNT_WIDTH  rises seen in PULSE or HOLDOFF.

Behaviour:
- Reset (rst high, async): state=IDLE, every output 0, edge register 0, internal counters 0.
- Edge detect: d1_q <= detect_pls_1 each cycle; rise = detect_pls_1 & ~d1_q & trig_enable.
- States:
  - IDLE: on rise in cycle N, go to PULSE. trig_out=1 from N+1 (latency 1 cycle). Load width counter with max(pulse_width,1). Capture tof_latched <= pulse_tof sampled in cycle N. Set tof_valid. event_count++.
  - PULSE: trig_out=1. Decrement width counter; after exactly max(pulse_width,1) high cycles, trig_out=0. If holdoff==0 go to IDLE, else go to HOLDOFF with counter=holdoff.
  - HOLDOFF: trig_out=0. Decrement; after exactly holdoff cycles go to IDLE.
  - So the earliest new accepted rise is cycle N+W+H+1.
- pulse_width and holdoff are sampled only when loaded; changes mid-pulse have no effect.
- Rise in PULSE or HOLDOFF: ignored for trigger; missed_count++. No TOF capture.
- Counters saturate at all-ones, no wrap. cnt_clr wins over a same-cycle increment (result 0).
- Handshake:
  - tof_ack high clears tof_valid next cycle.
  - Capture and tof_ack in the same cycle: capture wins; tof_valid stays 1 and tof_overrun is not set.
  - Capture while tof_valid=1 and no ack: overwrite tof_latched and set tof_overrun.
  - tof_overrun clears only on rst or cnt_clr.
- trig_enable low (synchronous, any state):
  - Next cycle: state=IDLE, trig_out=0, pls0_out=0.
  - A pulse in progress is truncated.
  - tof_latched, tof_valid and counters are kept.
  - d1_q keeps tracking, so a level already high at re-enable gives no rise.
- pls0_out <= detect_pls_0 & trig_enable, 1-cycle latency.
- Async rst mid-pulse: trig_out drops immediately, without waiting for a clock edge.

Optional Feature:
- Macro: TRIG_OUT_SYNC_EN.
- Defined: detect_pls_0 and detect_pls_1 each pass through a 2-flop synchronizer, reset to 0, before edge detect and pls0_out. Input-to-trig_out latency becomes 3 cycles and pls0_out latency becomes 3 cycles. Captured pulse_tof is delayed by the same 2 cycles so the TOF matches its trigger.
- Undefined: no synchronizer; latencies as in Behaviour.

Test Plan:
- Basic pulse: reset, trig_enable=1, pulse_width=4, holdoff=0, pulse_tof=0x0000_1234, detect_pls_1 0->1 at cycle 10 -> trig_out high cycles 11-14; tof_latched=0x1234; tof_valid=1; event_count=1.
- Width zero and holdoff: pulse_width=0, holdoff=5, rise at cycle 10, second rise at cycle 13 -> trig_out high only cycle 11; missed_count=1; armed returns at cycle 17; rise at 17 is accepted.
- Handshake overrun: two accepted triggers with no tof_ack, TOF 0x10 then 0x20 -> tof_latched=0x20, tof_overrun=1. Then tof_ack -> tof_valid=0 next cycle; tof_overrun remains 1 until cnt_clr.
- Simultaneous capture and ack: tof_ack high in the rise cycle -> tof_valid stays 1, tof_overrun stays 0.
- Enable abort: pulse_width=100, drop trig_enable at pulse cycle 20 -> trig_out=0 next cycle, state IDLE. detect_pls_1 still high at re-enable -> no new trigger.
- Saturation and clear: CNT_WIDTH=4, 20 accepted triggers -> event_count=15. Assert cnt_clr together with a rise -> event_count=0. Async rst mid-pulse -> trig_out=0 without a clock edge.
